layer_mac_scheduler: RTL and testbench
======================================

// Module: layer_mac_scheduler
// PURPOSE
//  Sequences one fully-connected ANN layer on a single shared MAC/accumulator datapath.
//  Per neuron: clear the accumulator, stream N_IN input/weight addresses, and enable the accumulator once per returned operand pair.
//  It then writes the neuron sum to the layer output buffer.
//  Sits between the top-level inference FSM (start/done) and the input RAM, weight ROM, accumulator and activation/output buffer.
// PARAMETERS
//  N_IN     784  inputs per neuron (>=2)
//  N_OUT    10   neurons in layer (>=1)
//  RD_LAT   1    input/weight memory read latency, cycles (1..4)
//  IN_AW    10   input address width, >= clog2(N_IN)
//  W_AW     13   weight address width, >= clog2(N_IN*N_OUT [+N_OUT with bias])
//  OUT_AW   4    output address width, >= clog2(N_OUT)
// PORTS
//  clk       in   1       clock
//  reset     in   1       synchronous, active-high reset
//  start     in   1       begin layer; sampled only in IDLE
//  busy      out  1       high from cycle after start until DONE inclusive
//  done      out  1       1-cycle pulse, layer complete
//  in_addr   out  IN_AW   input buffer read address
//  w_addr    out  W_AW    weight ROM read address
//  acc_clr   out  1       accumulator synchronous clear
//  acc_en    out  1       accumulate operand pair present this cycle
//  out_we    out  1       write accumulator result to output buffer
//  out_addr  out  OUT_AW  neuron index for out_we
//  acc_bias  out  1       (LAYER_BIAS_EN only) operand this cycle is bias, not in*w
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, read-valid pipe flushed; applies mid-layer, no write issued.
//  FSM: IDLE -> CLEAR -> [BIAS] -> MAC -> DRAIN -> WRITE -> (CLEAR | DONE) -> IDLE.
//  IDLE: start=1 -> CLEAR; neuron=0, w_addr=0. start ignored in every other state (no queueing).
//  CLEAR (1 cyc): acc_clr=1; in_idx=0.
//  MAC (N_IN cyc): in_addr=in_idx, w_addr=running weight ptr; both increment each cycle.
//   Ptr is neuron*N_IN+in_idx, kept as an incrementing counter (no multiplier).
//   Exit after in_idx==N_IN-1 issued.
//  Issue-valid bit delayed RD_LAT cycles by shift register -> acc_en; exactly N_IN acc_en pulses/neuron.
//  DRAIN (RD_LAT cyc): no new reads; last acc_en occurs in final DRAIN cycle.
//  WRITE (1 cyc): out_we=1, out_addr=neuron. Next: CLEAR with neuron+1, or DONE if neuron==N_OUT-1.
//  DONE (1 cyc): done=1, busy=1 -> IDLE. busy=0 in IDLE.
//  Per-neuron cycles = N_IN+RD_LAT+2.
//  done asserts N_OUT*(N_IN+RD_LAT+2)+1 cycles after the edge where start was sampled.
//  acc_clr and acc_en never high in the same cycle; out_we never overlaps acc_en.
//  Addresses hold last value when not issuing; consumers qualify with acc_en/out_we.
// CONFIGURATION
//  LAYER_BIAS_EN defined: BIAS state (1 cyc) between CLEAR and MAC.
//   Issues w_addr = N_IN*N_OUT + neuron; acc_bias and acc_en pulse together RD_LAT cycles later.
//   Per-neuron cycles = N_IN+RD_LAT+3; N_IN+1 acc_en pulses per neuron.
//  LAYER_BIAS_EN undefined: no BIAS state, acc_bias port absent, timing as above.
// STRUCTURE
//  Shared package ann_pkg: state enum encoding, default N_IN/N_OUT/RD_LAT constants, address-width functions.
//  One sub-module: rd_valid_pipe (RD_LAT-deep valid/bias-tag shift register, sync reset).
//  FSM and counters stay in this module.
// TESTING (bench: N_IN=4, N_OUT=3, RD_LAT=1 unless noted)
//  1 start pulse -> in_addr 0,1,2,3 per neuron; w_addr 0..11 contiguous; 4 acc_en/neuron; out_we at out_addr 0,1,2; done 22 cycles after start.
//  2 start held high through layer + 2 cycles -> single layer run; second run starts only from IDLE after done.
//  3 reset asserted during neuron 1 MAC -> next cycle all outputs 0, no out_we; new start -> full correct run from neuron 0.
//  4 RD_LAT=3 -> acc_en lags address issue by 3; DRAIN 3 cycles; done at 3*(4+3+2)+1=28.
//  5 N_OUT=1 -> CLEAR, MAC, DRAIN, WRITE, DONE once; done at 8.
//  6 LAYER_BIAS_EN -> bias read w_addr 12,13,14 with acc_bias; 5 acc_en/neuron; done at 3*8+1=25.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared definitions for the ANN layer sequencer: FSM state encoding, default layer
// dimensions and address-width helpers.
package ann_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_BIAS  = 3'd2,
    ST_MAC   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } layer_state_e;

  localparam int DEF_N_IN   = 784;
  localparam int DEF_N_OUT  = 10;
  localparam int DEF_RD_LAT = 1;

  function automatic int addr_w(input int depth);
    return (depth <= 32'sd1) ? 32'sd1 : $clog2(depth);
  endfunction

  // Weight space holds the N_OUT bias words after the N_IN*N_OUT products when bias is used.
  function automatic int weight_aw(input int n_in, input int n_out, input bit bias);
    return addr_w(n_in * n_out + (bias ? n_out : 32'sd0));
  endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// RD_LAT-deep shift register carrying the issue-valid bit (and the bias tag when present)
// so it lines up with data returning from the input RAM / weight ROM.
module rd_valid_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_r [DEPTH];

  // Shift one stage per cycle; reset flushes every in-flight tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= '0;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/layer_mac_scheduler.sv
// Sequences one fully-connected layer over a shared MAC/accumulator: clear, stream operands,
// drain the read pipe, write the neuron sum. Optional bias word per neuron: LAYER_BIAS_EN.
module layer_mac_scheduler
  import ann_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int IN_AW  = addr_w(N_IN),
`ifdef LAYER_BIAS_EN
  parameter int W_AW   = weight_aw(N_IN, N_OUT, 1'b1),
`else
  parameter int W_AW   = weight_aw(N_IN, N_OUT, 1'b0),
`endif
  parameter int OUT_AW = addr_w(N_OUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr
`ifdef LAYER_BIAS_EN
  ,
  output logic              acc_bias
`endif
);

`ifdef LAYER_BIAS_EN
  localparam int TAG_W = 2;
`else
  localparam int TAG_W = 1;
`endif

  layer_state_e      state_r, state_s;
  logic [OUT_AW-1:0] neuron_r, neuron_s;
  logic [IN_AW-1:0]  in_idx_r, in_idx_s;
  logic [W_AW-1:0]   w_ptr_r, w_ptr_s;
  logic [2:0]        drain_r, drain_s;
  logic              issue_r, issue_s;
  logic [IN_AW-1:0]  in_addr_s;
  logic [W_AW-1:0]   w_addr_s;
  logic [OUT_AW-1:0] out_addr_s;
  logic [TAG_W-1:0]  pipe_in_s, pipe_out_s;
`ifdef LAYER_BIAS_EN
  logic              bias_issue_r, bias_issue_s;
`endif

  // Next-state and counter update; outputs are derived from the next state and registered.
  always_comb begin
    state_s  = state_r;
    neuron_s = neuron_r;
    in_idx_s = in_idx_r;
    w_ptr_s  = w_ptr_r;
    drain_s  = drain_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s  = ST_CLEAR;
          neuron_s = '0;
          w_ptr_s  = '0;
          in_idx_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
`ifdef LAYER_BIAS_EN
      ST_CLEAR: state_s = ST_BIAS;
`else
      ST_CLEAR: state_s = ST_MAC;
`endif
      ST_BIAS:  state_s = ST_MAC;
      ST_MAC: begin
        // in_addr holds the index issued this cycle
        if (in_addr == IN_AW'(N_IN - 1)) begin
          state_s = ST_DRAIN;
          drain_s = 3'd0;
        end else begin
          state_s = ST_MAC;
        end
      end
      ST_DRAIN: begin
        if (drain_r == 3'(RD_LAT - 1)) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_DRAIN;
          drain_s = drain_r + 3'd1;
        end
      end
      ST_WRITE: begin
        if (neuron_r == OUT_AW'(N_OUT - 1)) begin
          state_s = ST_DONE;
        end else begin
          state_s  = ST_CLEAR;
          neuron_s = neuron_r + OUT_AW'(1'b1);
          in_idx_s = '0;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase

    issue_s   = 1'b0;
    in_addr_s = in_addr;
    w_addr_s  = w_addr;
`ifdef LAYER_BIAS_EN
    bias_issue_s = 1'b0;
`endif
    if (state_s == ST_MAC) begin
      issue_s   = 1'b1;
      in_addr_s = in_idx_r;
      w_addr_s  = w_ptr_r;
      in_idx_s  = in_idx_r + IN_AW'(1'b1);
      w_ptr_s   = w_ptr_r + W_AW'(1'b1);
    end
`ifdef LAYER_BIAS_EN
    else if (state_s == ST_BIAS) begin
      // Bias words sit after the whole product weight block; the product pointer is untouched.
      issue_s      = 1'b1;
      bias_issue_s = 1'b1;
      w_addr_s     = W_AW'(N_IN * N_OUT) + W_AW'(neuron_r);
    end
`endif
    else begin
      issue_s = 1'b0;
    end

    if (state_s == ST_WRITE) begin
      out_addr_s = neuron_r;
    end else begin
      out_addr_s = out_addr;
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      neuron_r <= '0;
      in_idx_r <= '0;
      w_ptr_r  <= '0;
      drain_r  <= 3'd0;
      issue_r  <= 1'b0;
      in_addr  <= '0;
      w_addr   <= '0;
      out_addr <= '0;
      acc_clr  <= 1'b0;
      out_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      neuron_r <= neuron_s;
      in_idx_r <= in_idx_s;
      w_ptr_r  <= w_ptr_s;
      drain_r  <= drain_s;
      issue_r  <= issue_s;
      in_addr  <= in_addr_s;
      w_addr   <= w_addr_s;
      out_addr <= out_addr_s;
      acc_clr  <= (state_s == ST_CLEAR);
      out_we   <= (state_s == ST_WRITE);
      busy     <= (state_s != ST_IDLE);
      done     <= (state_s == ST_DONE);
    end
  end

`ifdef LAYER_BIAS_EN
  // Bias tag travels with the issue bit through the read pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      bias_issue_r <= 1'b0;
    end else begin
      bias_issue_r <= bias_issue_s;
    end
  end

  assign pipe_in_s = {bias_issue_r, issue_r};
  assign acc_bias  = pipe_out_s[1];
`else
  assign pipe_in_s = issue_r;
`endif
  assign acc_en = pipe_out_s[0];

  rd_valid_pipe #(
    .DEPTH (RD_LAT),
    .W     (TAG_W)
  ) u_rd_valid_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (pipe_in_s),
    .q     (pipe_out_s)
  );

endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Scoreboard bench for layer_mac_scheduler: three instances (N_OUT=3/RD_LAT=1, RD_LAT=3, N_OUT=1);
// expected events are queued at launch and matched by a per-cycle monitor.
module tb_layer_mac_scheduler;

  localparam int N_IN   = 4;
  localparam int IN_AW  = 3;
  localparam int W_AW   = 5;
  localparam int OUT_AW = 2;
`ifdef LAYER_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  localparam int EV_CLR = 0, EV_ACC = 1, EV_WE = 2, EV_DONE = 3;

  function automatic int nout_of(input int s);
    return (s == 2) ? 1 : 3;
  endfunction
  function automatic int lat_of(input int s);
    return (s == 1) ? 3 : 1;
  endfunction

  typedef struct {
    int cyc;
    int kind;
    int in_a;
    int w_a;
    int aux;
    bit chk_in;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] start_v;
  logic [2:0] busy_v, done_v, acc_clr_v, acc_en_v, out_we_v, acc_bias_v;
  logic [2:0][IN_AW-1:0]  in_addr_v;
  logic [2:0][W_AW-1:0]   w_addr_v;
  logic [2:0][OUT_AW-1:0] out_addr_v;

  ev_t q[$];
  bit  exp_busy [128];
  int  hist_in [128];
  int  hist_w [128];
  int  checks = 0, errors = 0;
  int  cyc = 0, sel = 0;
  bit  mon_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    layer_mac_scheduler #(
      .N_IN(N_IN), .N_OUT(nout_of(g)), .RD_LAT(lat_of(g)),
      .IN_AW(IN_AW), .W_AW(W_AW), .OUT_AW(OUT_AW)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .in_addr(in_addr_v[g]), .w_addr(w_addr_v[g]), .acc_clr(acc_clr_v[g]), .acc_en(acc_en_v[g]),
      .out_we(out_we_v[g]), .out_addr(out_addr_v[g])
`ifdef LAYER_BIAS_EN
      , .acc_bias(acc_bias_v[g])
`endif
    );
  end
`ifndef LAYER_BIAS_EN
  assign acc_bias_v = 3'b000;
`endif

  logic [IN_AW-1:0]  m_in;
  logic [W_AW-1:0]   m_w;
  logic [OUT_AW-1:0] m_oa;
  logic m_busy, m_done, m_clr, m_en, m_we, m_bias;
  assign m_in   = in_addr_v[sel];
  assign m_w    = w_addr_v[sel];
  assign m_oa   = out_addr_v[sel];
  assign m_busy = busy_v[sel];
  assign m_done = done_v[sel];
  assign m_clr  = acc_clr_v[sel];
  assign m_en   = acc_en_v[sel];
  assign m_we   = out_we_v[sel];
  assign m_bias = acc_bias_v[sel];

  // Reference model: expected event stream for one layer run whose start is sampled at 'offset'.
  task automatic push_run(input int offset, input int s, output int done_c);
    int lat, nout, per, base;
    lat  = lat_of(s);
    nout = nout_of(s);
    per  = N_IN + lat + 2 + B;
    for (int n = 0; n < nout; n++) begin
      base = offset + 1 + n * per;
      q.push_back('{base, EV_CLR, 0, 0, 0, 1'b0});
      if (B == 1) q.push_back('{base + 1 + lat, EV_ACC, 0, N_IN * nout + n, 1, 1'b0});
      for (int j = 0; j < N_IN; j++)
        q.push_back('{base + 1 + B + j + lat, EV_ACC, j, n * N_IN + j, 0, 1'b1});
      q.push_back('{base + per - 1, EV_WE, 0, 0, n, 1'b0});
    end
    done_c = offset + nout * per + 1;
    q.push_back('{done_c, EV_DONE, 0, 0, 0, 1'b0});
    for (int c = offset + 1; c <= done_c; c++) exp_busy[c] = 1'b1;
  endtask

  // Monitor: every cycle of a run, check busy and pop/compare each observed output event.
  always @(posedge clk) begin
    #1;
    if (mon_on && cyc < 127) begin
      int kind, idx, n_ev;
      ev_t e;
      cyc = cyc + 1;
      hist_in[cyc] = int'(m_in);
      hist_w[cyc]  = int'(m_w);
      checks++;
      if (m_busy !== exp_busy[cyc]) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b expected %b", cyc, m_busy, exp_busy[cyc]);
      end
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event kind=%0d expected at cyc %0d, now %0d", e.kind, e.cyc, cyc);
      end
      n_ev = int'(m_clr) + int'(m_en) + int'(m_we) + int'(m_done);
      checks++;
      if (n_ev > 1) begin
        errors++;
        $display("FAIL overlap cyc=%0d clr=%b en=%b we=%b done=%b expected at most one", cyc, m_clr, m_en, m_we, m_done);
      end
      if (n_ev != 0) begin
        kind = m_done ? EV_DONE : m_we ? EV_WE : m_en ? EV_ACC : EV_CLR;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d kind=%0d expected none", cyc, kind);
        end else begin
          e = q.pop_front();
          if (kind !== e.kind || cyc !== e.cyc) begin
            errors++;
            $display("FAIL event got kind %0d at cyc %0d expected kind %0d at cyc %0d", kind, cyc, e.kind, e.cyc);
          end else if (kind == EV_ACC) begin
            idx = cyc - lat_of(sel);
            if (hist_w[idx] !== e.w_a || (e.chk_in && hist_in[idx] !== e.in_a) || int'(m_bias) !== e.aux) begin
              errors++;
              $display("FAIL acc_operand cyc=%0d got in %0d w %0d bias %b expected in %0d w %0d bias %0d",
                       cyc, hist_in[idx], hist_w[idx], m_bias, e.in_a, e.w_a, e.aux);
            end
          end else if (kind == EV_WE && int'(m_oa) !== e.aux) begin
            errors++;
            $display("FAIL out_addr cyc=%0d got %0d expected %0d", cyc, m_oa, e.aux);
          end
        end
      end
    end
  end

  // Stimulus: clear the scoreboard, queue expectations and pulse (or hold) start on instance s.
  task automatic launch(input int s, input bit hold, output int done_c);
    int d2;
    q.delete();
    exp_busy = '{default: 1'b0};
    sel = s;
    push_run(0, s, done_c);
    if (hold) push_run(done_c + 1, s, d2);
    @(negedge clk);
    start_v[s] = 1'b1;
    @(posedge clk);
    cyc    = 0;
    mon_on = 1'b1;
    if (!hold) begin
      @(negedge clk);
      start_v[s] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start_v = 3'b000;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      @(negedge clk);
      checks++;
      if ({m_in, m_w, m_oa, m_busy, m_done, m_clr, m_en, m_we, m_bias} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d got in %0d w %0d oa %0d busy %b done %b clr %b en %b we %b expected all 0",
                 s, m_in, m_w, m_oa, m_busy, m_done, m_clr, m_en, m_we);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_layer(input int s);
    int d;
    launch(s, 1'b0, d);
    repeat (d + 2) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b0;
    checks++;
    if (q.size() != 0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL layer_end dut=%0d pending %0d busy %b expected 0 pending and busy 0", s, q.size(), m_busy);
    end
  endtask

  task automatic test_start_held();
    int d;
    launch(0, 1'b1, d);
    repeat (d + 1) @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (d + 1) @(posedge clk);
    @(negedge clk);
    mon_on = 1'b0;
    checks++;
    if (q.size() != 0 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_held_end pending %0d busy %b expected 0 pending and busy 0", q.size(), m_busy);
    end
  endtask

  task automatic test_mid_reset();
    int d;
    launch(0, 1'b0, d);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    mon_on = 1'b0;
    #1;
    checks++;
    if ({m_in, m_w, m_oa, m_busy, m_done, m_clr, m_en, m_we, m_bias} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got in %0d w %0d oa %0d busy %b done %b clr %b en %b we %b expected all 0",
               m_in, m_w, m_oa, m_busy, m_done, m_clr, m_en, m_we);
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_we !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle k=%0d out_we %b busy %b expected 0 0", k, m_we, m_busy);
      end
    end
    test_layer(0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_layer(0);
    test_start_held();
    test_mid_reset();
    test_layer(1);
    test_layer(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
